// File: rtl/plic_claim_agent_if.sv
// Register-bus channel between the claim agent (master) and the PLIC port (slave).
interface plic_claim_agent_if;
  logic        valid;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;
  logic        error;

  modport master (output valid, write, addr, wdata, wstrb,
                  input  ready, rdata, error);
  modport slave  (input  valid, write, addr, wdata, wstrb,
                  output ready, rdata, error);
endinterface

// File: rtl/plic_claim_agent.sv
// PLIC claim/complete initiator for one interrupt context.
// Optional PLIC_CLAIM_AGENT_STATS_EN adds claim/spurious/error counters.
module plic_claim_agent #(
  parameter int          N_SOURCE  = 30,
  parameter int          SRCW      = $clog2(N_SOURCE + 1),
  parameter logic [31:0] PLIC_BASE = 32'h0C00_0000,
  parameter int          CONTEXT   = 0,
  parameter int          HOLDOFF   = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              eip_i,
  plic_claim_agent_if.master bus,
  output logic              irq_valid_o,
  output logic [SRCW-1:0]   irq_id_o,
  input  logic              irq_ready_i,
  input  logic              irq_done_i,
  output logic              busy_o,
  output logic              bus_err_o
`ifdef PLIC_CLAIM_AGENT_STATS_EN
  ,
  output logic [15:0]       claim_cnt_o,
  output logic [15:0]       spurious_cnt_o,
  output logic [15:0]       err_cnt_o
`endif
);

  // state     | meaning
  // S_IDLE    | waiting for eip_i with holdoff expired
  // S_CLAIM   | claim read outstanding
  // S_DISPATCH| ID offered to consumer
  // S_WAIT_DONE| consumer servicing the interrupt
  // S_COMPLETE| completion write outstanding
  typedef enum logic [2:0] {
    S_IDLE, S_CLAIM, S_DISPATCH, S_WAIT_DONE, S_COMPLETE
  } state_t;

  localparam logic [31:0] CLAIM_ADDR =
    PLIC_BASE + 32'h0020_0004 + 32'(CONTEXT) * 32'h0000_1000;

  state_t          state_q, state_d;
  logic [SRCW-1:0] id_q;
  logic [7:0]      hold_q;
  logic            err_q;

  logic id_load, hold_load, err_set, spur, claim_ok;
  logic is_spurious;

  assign is_spurious = (bus.rdata[SRCW-1:0] == '0) || (bus.rdata > 32'(N_SOURCE));

  always_comb begin
    state_d   = state_q;
    id_load   = 1'b0;
    hold_load = 1'b0;
    err_set   = 1'b0;
    spur      = 1'b0;
    claim_ok  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (eip_i && hold_q == 8'd0) state_d = S_CLAIM;
      end
      S_CLAIM: begin
        if (bus.ready) begin
          if (bus.error) begin
            err_set = 1'b1;
            state_d = S_IDLE;
          end else if (is_spurious) begin
            spur      = 1'b1;
            hold_load = 1'b1;
            state_d   = S_IDLE;
          end else begin
            claim_ok = 1'b1;
            id_load  = 1'b1;
            state_d  = S_DISPATCH;
          end
        end
      end
      S_DISPATCH: begin
        if (irq_ready_i) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (irq_done_i) state_d = S_COMPLETE;
      end
      S_COMPLETE: begin
        if (bus.ready) begin
          // A failed completion is not retried; holdoff still guards the stale eip level.
          hold_load = 1'b1;
          err_set   = bus.error;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus request is a pure function of the state register, so it is stable while waiting.
  assign bus.valid = (state_q == S_CLAIM) || (state_q == S_COMPLETE);
  assign bus.write = (state_q == S_COMPLETE);
  assign bus.addr  = bus.valid ? CLAIM_ADDR : 32'h0;
  assign bus.wdata = (state_q == S_COMPLETE) ? {{(32-SRCW){1'b0}}, id_q} : 32'h0;
  assign bus.wstrb = (state_q == S_COMPLETE) ? 4'hF : 4'h0;

  assign irq_valid_o = (state_q == S_DISPATCH);
  assign irq_id_o    = id_q;
  assign busy_o      = (state_q != S_IDLE);
  assign bus_err_o   = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      hold_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_set;
      if (id_load) id_q <= bus.rdata[SRCW-1:0];
      if (hold_load)          hold_q <= 8'(HOLDOFF);
      else if (hold_q != 8'd0) hold_q <= hold_q - 8'd1;
    end
  end

`ifdef PLIC_CLAIM_AGENT_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      claim_cnt_o    <= 16'h0;
      spurious_cnt_o <= 16'h0;
      err_cnt_o      <= 16'h0;
    end else begin
      if (claim_ok) claim_cnt_o    <= claim_cnt_o + 16'h1;
      if (spur)     spurious_cnt_o <= spurious_cnt_o + 16'h1;
      if (err_set)  err_cnt_o      <= err_cnt_o + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_plic_claim_agent.sv
// Directed self-checking bench for plic_claim_agent (CONTEXT=1, HOLDOFF=64).
module tb_plic_claim_agent;
  localparam int SRCW = 5;
  localparam logic [31:0] ADDR = 32'h0C20_1004;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic eip = 1'b0;
  logic irq_valid;
  logic [SRCW-1:0] irq_id;
  logic irq_ready = 1'b0;
  logic irq_done = 1'b0;
  logic busy, bus_err;
`ifdef PLIC_CLAIM_AGENT_STATS_EN
  logic [15:0] claim_cnt, spurious_cnt, err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  plic_claim_agent_if bus ();

  plic_claim_agent #(.N_SOURCE(30), .CONTEXT(1), .HOLDOFF(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .eip_i(eip), .bus(bus.master),
    .irq_valid_o(irq_valid), .irq_id_o(irq_id), .irq_ready_i(irq_ready),
    .irq_done_i(irq_done), .busy_o(busy), .bus_err_o(bus_err)
`ifdef PLIC_CLAIM_AGENT_STATS_EN
    , .claim_cnt_o(claim_cnt), .spurious_cnt_o(spurious_cnt), .err_cnt_o(err_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic serve(input string name, input int waits, input logic [31:0] rd,
                       input logic er, input logic exp_wr, input logic [31:0] exp_wd,
                       output int t_start, output int t_cmp);
    int n = 0;
    logic [68:0] exp_pack, got_pack;
    while (bus.valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    t_start = cyc;
    checks++;
    if (bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: valid=%b required 1", name, bus.valid);
    end
    exp_pack = {exp_wr, ADDR, exp_wr ? exp_wd : 32'h0, exp_wr ? 4'hF : 4'h0};
    got_pack = {bus.write, bus.addr, bus.wdata, bus.wstrb};
    checks++;
    if (got_pack !== exp_pack) begin
      errors++;
      $display("FAIL %s_fields: write/addr/wdata/wstrb=%h required %h", name, got_pack, exp_pack);
    end
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      got_pack = {bus.write, bus.addr, bus.wdata, bus.wstrb};
      checks++;
      if (bus.valid !== 1'b1 || got_pack !== exp_pack) begin
        errors++;
        $display("FAIL %s_stable: valid=%b fields=%h required 1 %h", name, bus.valid, got_pack, exp_pack);
      end
    end
    bus.ready = 1'b1;
    bus.rdata = rd;
    bus.error = er;
    t_cmp = cyc;
    @(negedge clk);
    bus.ready = 1'b0;
    bus.rdata = 32'h0;
    bus.error = 1'b0;
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid_drop: valid=%b required 0", name, bus.valid);
    end
    checks++;
    if (bus_err !== er) begin
      errors++;
      $display("FAIL %s_bus_err: bus_err=%b required %b", name, bus_err, er);
    end
  endtask

  task automatic handshake(input string name, input logic [SRCW-1:0] id, input int delay);
    for (int i = 0; i <= delay; i++) begin
      checks++;
      if (irq_valid !== 1'b1 || irq_id !== id) begin
        errors++;
        $display("FAIL %s_offer: valid=%b id=%0d required 1 %0d", name, irq_valid, irq_id, id);
      end
      if (i < delay) @(negedge clk);
    end
    irq_ready = 1'b1;
    irq_done  = 1'b1;
    @(negedge clk);
    irq_ready = 1'b0;
    irq_done  = 1'b0;
    checks++;
    if (irq_valid !== 1'b0 || irq_id !== id) begin
      errors++;
      $display("FAIL %s_accept: valid=%b id=%0d required 0 %0d", name, irq_valid, irq_id, id);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_wait_done: valid=%b busy=%b required 0 1", name, bus.valid, busy);
      end
    end
    irq_done = 1'b1;
    @(negedge clk);
    irq_done = 1'b0;
  endtask

  task automatic check_gap(input string name, input int gap, input int lo, input int hi);
    checks++;
    if (gap < lo || gap > hi) begin
      errors++;
      $display("FAIL %s_gap: cycles=%0d required %0d..%0d", name, gap, lo, hi);
    end
  endtask

  task automatic check_dispatch(input string name, input logic exp_v, input logic [SRCW-1:0] id);
    checks++;
    if (irq_valid !== exp_v || (exp_v && irq_id !== id)) begin
      errors++;
      $display("FAIL %s_dispatch: valid=%b id=%0d required %b %0d", name, irq_valid, irq_id, exp_v, id);
    end
  endtask

  int ts, tc, t_done;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.valid, bus.write, bus.addr, bus.wdata, bus.wstrb} !== 70'h0 ||
        irq_valid !== 1'b0 || irq_id !== '0 || busy !== 1'b0 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b irq_valid=%b id=%0d busy=%b err=%b required all 0",
               bus.valid, irq_valid, irq_id, busy, bus_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_claim();
    eip = 1'b1;
    serve("claim5", 2, 32'd5, 1'b0, 1'b0, 32'h0, ts, tc);
    check_dispatch("claim5", 1'b1, 5'd5);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL claim5_busy: busy=%b required 1", busy);
    end
  endtask

  task automatic test_complete();
    handshake("h5", 5'd5, 3);
    serve("complete5", 0, 32'h0, 1'b0, 1'b1, 32'd5, ts, t_done);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL complete5_busy: busy=%b required 0", busy);
    end
  endtask

  task automatic test_spurious();
    serve("spur0", 0, 32'd0, 1'b0, 1'b0, 32'h0, ts, tc);
    check_gap("holdoff_complete", ts - t_done, 64, 70);
    check_dispatch("spur0", 1'b0, '0);
    repeat (3) @(negedge clk);
    check_dispatch("spur0_late", 1'b0, '0);
    t_done = tc;
    serve("spur31", 0, 32'd31, 1'b0, 1'b0, 32'h0, ts, tc);
    check_gap("holdoff_spur0", ts - t_done, 64, 70);
    check_dispatch("spur31", 1'b0, '0);
    t_done = tc;
`ifdef PLIC_CLAIM_AGENT_STATS_EN
    checks++;
    if (spurious_cnt !== 16'd2 || claim_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stats_spurious: spurious=%0d claim=%0d required 2 1", spurious_cnt, claim_cnt);
    end
`endif
  endtask

  task automatic test_bus_error();
    serve("claim_err", 0, 32'd4, 1'b1, 1'b0, 32'h0, ts, tc);
    check_gap("holdoff_spur31", ts - t_done, 64, 70);
    check_dispatch("claim_err", 1'b0, '0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL claim_err_busy: busy=%b required 0", busy);
    end
    t_done = tc;
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL claim_err_pulse: bus_err=%b required 0", bus_err);
    end
    serve("claim7", 1, 32'd7, 1'b0, 1'b0, 32'h0, ts, tc);
    check_gap("no_holdoff_after_err", ts - t_done, 1, 3);
    check_dispatch("claim7", 1'b1, 5'd7);
    handshake("h7", 5'd7, 0);
    serve("complete_err", 0, 32'h0, 1'b1, 1'b1, 32'd7, ts, t_done);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL complete_err_busy: busy=%b required 0", busy);
    end
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL complete_err_pulse: bus_err=%b required 0", bus_err);
    end
`ifdef PLIC_CLAIM_AGENT_STATS_EN
    checks++;
    if (err_cnt !== 16'd2 || claim_cnt !== 16'd2) begin
      errors++;
      $display("FAIL stats_err: err=%0d claim=%0d required 2 2", err_cnt, claim_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    serve("claim3", 0, 32'd3, 1'b0, 1'b0, 32'h0, ts, tc);
    check_gap("holdoff_complete_err", ts - t_done, 64, 70);
    check_dispatch("claim3", 1'b1, 5'd3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (irq_valid !== 1'b0 || bus.valid !== 1'b0 || busy !== 1'b0 || irq_id !== '0) begin
      errors++;
      $display("FAIL mid_reset: irq_valid=%b valid=%b busy=%b id=%0d required 0 0 0 0",
               irq_valid, bus.valid, busy, irq_id);
    end
    serve("claim9", 0, 32'd9, 1'b0, 1'b0, 32'h0, ts, tc);
    check_dispatch("claim9", 1'b1, 5'd9);
    handshake("h9", 5'd9, 1);
    serve("complete9", 0, 32'h0, 1'b0, 1'b1, 32'd9, ts, t_done);
`ifdef PLIC_CLAIM_AGENT_STATS_EN
    checks++;
    if (claim_cnt !== 16'd1 || spurious_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stats_after_reset: claim=%0d spur=%0d err=%0d required 1 0 0",
               claim_cnt, spurious_cnt, err_cnt);
    end
`endif
  endtask

  initial begin
    bus.ready = 1'b0;
    bus.rdata = 32'h0;
    bus.error = 1'b0;
    @(negedge clk);
    test_reset();
    test_claim();
    test_complete();
    test_spurious();
    test_bus_error();
    test_reset_mid();
    eip = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
